// File: rtl/xgmii_tx_sched.sv
// Shares one 64-bit XGMII TX lane between the measurement generator and the control responder.
// Grants only at frame boundaries, enforces a fixed IPG, bounds control bursts, aborts runaways.
module xgmii_tx_sched #(
  parameter int unsigned IPG_WORDS       = 2,
  parameter int unsigned MAX_CTRL_BURST  = 4,
  parameter int unsigned MAX_FRAME_WORDS = 1200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sec_oneshot,
  input  logic        tx_enable,
  input  logic        gen_req,
  input  logic [63:0] gen_txd,
  input  logic [7:0]  gen_txc,
  input  logic        gen_eof,
  output logic        gen_gnt,
  input  logic        ctl_req,
  input  logic [63:0] ctl_txd,
  input  logic [7:0]  ctl_txc,
  input  logic        ctl_eof,
  output logic        ctl_gnt,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [31:0] gen_fps,
  output logic [31:0] ctl_fps,
  output logic [15:0] abort_count
);

  localparam logic [63:0] IDLE_TXD  = 64'h0707070707070707;
  localparam logic [63:0] ABORT_TXD = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [3:0]  IPG_LAST  = 4'(IPG_WORDS - 1);
  localparam logic [15:0] BURST_MAX = 16'(MAX_CTRL_BURST);
  // Last granted word index that may still be forwarded before the abort word.
  localparam logic [15:0] WD_LAST   = 16'(MAX_FRAME_WORDS - 2);

  typedef enum logic [1:0] {StIdle, StGen, StCtl, StIpg} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [15:0] r_burst;
  logic [15:0] r_word_cnt;
  logic [3:0]  r_ipg_cnt;
  logic        r_abort_pend;
  logic [63:0] r_txd;
  logic [7:0]  r_txc;
  logic [31:0] r_gen_cnt;
  logic [31:0] r_ctl_cnt;
  logic [31:0] r_gen_fps;
  logic [31:0] r_ctl_fps;
  logic [15:0] r_abort_cnt;

  logic        w_gen_ok;
  logic        w_arb;
  logic        w_pick_ctl;
  logic        w_pick_gen;
  logic        w_in_frame;
  logic        w_sel_eof;
  logic        w_wd_trip;
  logic        w_gen_done;
  logic        w_ctl_done;
  logic [15:0] w_burst_inc;

  always_comb begin
    w_gen_ok    = gen_req && tx_enable;
    w_arb       = (r_state == StIdle) ||
                  ((r_state == StIpg) && !r_abort_pend && (r_ipg_cnt == IPG_LAST));
    w_pick_ctl  = ctl_req && (!w_gen_ok || (r_burst < BURST_MAX));
    w_pick_gen  = !w_pick_ctl && w_gen_ok;
    w_in_frame  = (r_state == StGen) || (r_state == StCtl);
    w_sel_eof   = (r_state == StGen) ? gen_eof : ctl_eof;
    w_wd_trip   = w_in_frame && !w_sel_eof && (r_word_cnt == WD_LAST);
    w_gen_done  = (r_state == StGen) && gen_eof;
    w_ctl_done  = (r_state == StCtl) && ctl_eof;
    w_burst_inc = (r_burst < BURST_MAX) ? r_burst + 16'd1 : r_burst;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StIpg: begin
        if (w_arb) begin
          if (w_pick_ctl)      w_state_d = StCtl;
          else if (w_pick_gen) w_state_d = StGen;
          else                 w_state_d = StIdle;
        end
      end
      StGen, StCtl: begin
        if (w_sel_eof || w_wd_trip) w_state_d = StIpg;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state      <= StIdle;
      r_burst      <= '0;
      r_word_cnt   <= '0;
      r_ipg_cnt    <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_word_cnt   <= w_in_frame ? r_word_cnt + 16'd1 : '0;
      // The abort word occupies its own slot, so the gap count starts after it.
      r_ipg_cnt    <= ((r_state == StIpg) && !r_abort_pend) ? r_ipg_cnt + 4'd1 : '0;
      r_abort_pend <= w_wd_trip;
      if (w_arb && w_pick_ctl) begin
        r_burst <= w_gen_ok ? w_burst_inc : 16'd1;
      end else if (w_arb && w_pick_gen) begin
        r_burst <= '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_txd <= IDLE_TXD;
      r_txc <= 8'hFF;
    end else begin
      unique case (r_state)
        StGen: begin
          r_txd <= gen_txd;
          r_txc <= gen_txc;
        end
        StCtl: begin
          r_txd <= ctl_txd;
          r_txc <= ctl_txc;
        end
        default: begin
          r_txd <= r_abort_pend ? ABORT_TXD : IDLE_TXD;
          r_txc <= 8'hFF;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_gen_cnt   <= '0;
      r_ctl_cnt   <= '0;
      r_gen_fps   <= '0;
      r_ctl_fps   <= '0;
      r_abort_cnt <= '0;
    end else begin
      // An eof on the second boundary belongs to the new period.
      if (sec_oneshot) begin
        r_gen_fps <= r_gen_cnt;
        r_ctl_fps <= r_ctl_cnt;
        r_gen_cnt <= {31'd0, w_gen_done};
        r_ctl_cnt <= {31'd0, w_ctl_done};
      end else begin
        if (w_gen_done) r_gen_cnt <= r_gen_cnt + 32'd1;
        if (w_ctl_done) r_ctl_cnt <= r_ctl_cnt + 32'd1;
      end
      if (w_wd_trip && (r_abort_cnt != 16'hFFFF)) r_abort_cnt <= r_abort_cnt + 16'd1;
    end
  end

  assign gen_gnt     = (r_state == StGen);
  assign ctl_gnt     = (r_state == StCtl);
  assign xgmii_txd   = r_txd;
  assign xgmii_txc   = r_txc;
  assign gen_fps     = r_gen_fps;
  assign ctl_fps     = r_ctl_fps;
  assign abort_count = r_abort_cnt;

endmodule

// File: tb/tb_xgmii_tx_sched.sv
// Directed bench for xgmii_tx_sched: modelled gen/ctl sources feed a scoreboard of expected
// output words that is checked against the XGMII stream every cycle.
module tb_xgmii_tx_sched;

  localparam int unsigned IPG   = 2;
  localparam int unsigned BURST = 4;
  localparam int unsigned MAXW  = 16;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] ABORT_W = 64'hFEFEFEFEFEFEFEFE;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n, sec_oneshot, tx_enable;
  logic        gen_req, gen_eof, gen_gnt, ctl_req, ctl_eof, ctl_gnt;
  logic [63:0] gen_txd, ctl_txd, xgmii_txd;
  logic [7:0]  gen_txc, ctl_txc, xgmii_txc;
  logic [31:0] gen_fps, ctl_fps;
  logic [15:0] abort_count;

  xgmii_tx_sched #(
    .IPG_WORDS      (IPG),
    .MAX_CTRL_BURST (BURST),
    .MAX_FRAME_WORDS(MAXW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sec_oneshot(sec_oneshot),
    .tx_enable  (tx_enable),
    .gen_req    (gen_req),
    .gen_txd    (gen_txd),
    .gen_txc    (gen_txc),
    .gen_eof    (gen_eof),
    .gen_gnt    (gen_gnt),
    .ctl_req    (ctl_req),
    .ctl_txd    (ctl_txd),
    .ctl_txc    (ctl_txc),
    .ctl_eof    (ctl_eof),
    .ctl_gnt    (ctl_gnt),
    .xgmii_txd  (xgmii_txd),
    .xgmii_txc  (xgmii_txc),
    .gen_fps    (gen_fps),
    .ctl_fps    (ctl_fps),
    .abort_count(abort_count)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish, required finish within budget");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [63:0] txd;
    logic        first;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] order[$];
  int n_pass, n_fail, n_total, cyc;
  int s_len[2], s_nfrm[2], s_idx[2], s_frm[2], n_gnt[2];
  int idle_run, abort_seen, abort_cyc, last_data_cyc, first_data_cyc;
  logic g_prev, c_prev, gap_armed, chk_gap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input int src, input int frm, input int idx);
    logic [31:0] hi;
    hi = {(src == 0) ? 8'h6E : 8'hC7, 8'(frm), 16'(idx)};
    return {hi, ~hi};
  endfunction

  task automatic present();
    gen_req = (s_nfrm[0] > 0);
    gen_txd = mkword(0, s_frm[0], s_idx[0]);
    gen_txc = 8'h00;
    gen_eof = (s_len[0] != 0) && (s_idx[0] == s_len[0] - 1);
    ctl_req = (s_nfrm[1] > 0);
    ctl_txd = mkword(1, s_frm[1], s_idx[1]);
    ctl_txc = 8'h00;
    ctl_eof = (s_len[1] != 0) && (s_idx[1] == s_len[1] - 1);
  endtask

  // Source consumed its current word: expect it on the lane next cycle.
  task automatic advance(input int s);
    exp_t e;
    e.txd   = mkword(s, s_frm[s], s_idx[s]);
    e.first = (s_idx[s] == 0);
    sb.push_back(e);
    n_gnt[s]++;
    if ((s_len[s] != 0) && (s_idx[s] == s_len[s] - 1)) begin
      s_idx[s] = 0;
      s_frm[s]++;
      s_nfrm[s]--;
    end else begin
      s_idx[s]++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (xgmii_txc === 8'hFF && xgmii_txd === IDLE_W) begin
      idle_run++;
    end else if (xgmii_txc === 8'hFF && xgmii_txd === ABORT_W) begin
      abort_seen++;
      abort_cyc = cyc;
      idle_run  = 0;
    end else begin
      if (sb.size() == 0) begin
        check("unexpected_word", xgmii_txd, IDLE_W);
      end else begin
        e = sb.pop_front();
        check("data_txd", xgmii_txd, e.txd);
        check("data_txc", 64'(xgmii_txc), 64'h0);
        if (e.first) begin
          if (chk_gap && gap_armed) check("ipg_len", 64'(idle_run), 64'(IPG));
          gap_armed = 1'b1;
          order.push_back(e.txd[63:56]);
          if (first_data_cyc < 0) first_data_cyc = cyc;
        end
        last_data_cyc = cyc;
      end
      idle_run = 0;
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    if (g_prev && sys_rst_n) advance(0);
    if (c_prev && sys_rst_n) advance(1);
    present();
    @(negedge sys_clk);
    cyc++;
    g_prev = gen_gnt;
    c_prev = ctl_gnt;
    monitor();
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (!(s_nfrm[0] == 0 && s_nfrm[1] == 0 && sb.size() == 0 && !gen_gnt && !ctl_gnt)
           && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done"}, 64'(k < budget), 64'd1);
    repeat (4) step();
  endtask

  task automatic sec_pulse();
    sec_oneshot = 1'b1;
    step();
    sec_oneshot = 1'b0;
  endtask

  initial begin
    int k, req_cyc, base;
    logic saw;
    logic [7:0] exp_ord[10];
    n_pass = 0; n_fail = 0; n_total = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      s_len[i] = 0; s_nfrm[i] = 0; s_idx[i] = 0; s_frm[i] = 0; n_gnt[i] = 0;
    end
    idle_run = 0; abort_seen = 0; abort_cyc = -1; last_data_cyc = -1; first_data_cyc = -1;
    g_prev = 1'b0; c_prev = 1'b0; gap_armed = 1'b0; chk_gap = 1'b0;
    sys_rst_n = 1'b0; sec_oneshot = 1'b0; tx_enable = 1'b1;
    present();
    step();
    step();
    check("rst_gen_gnt", 64'(gen_gnt), 64'd0);
    check("rst_ctl_gnt", 64'(ctl_gnt), 64'd0);
    check("rst_txd", xgmii_txd, IDLE_W);
    check("rst_txc", 64'(xgmii_txc), 64'hFF);
    check("rst_aborts", 64'(abort_count), 64'd0);
    sys_rst_n = 1'b1;
    step();

    // Single 8-word gen frame.
    s_len[0] = 8; s_nfrm[0] = 1; n_gnt[0] = 0; first_data_cyc = -1; req_cyc = cyc;
    present();
    step();
    check("t1_gnt_next_cycle", 64'(gen_gnt), 64'd1);
    drain("t1", 40);
    check("t1_gnt_cycles", 64'(n_gnt[0]), 64'd8);
    check("t1_first_word_lat", 64'(first_data_cyc - req_cyc), 64'd2);
    check("t1_idle_after", xgmii_txd, IDLE_W);

    // Continuous gen + ctl: control bursts bounded, fixed IPG between frames.
    sec_pulse();
    s_len[0] = 5; s_nfrm[0] = 2; s_len[1] = 8; s_nfrm[1] = 8;
    order.delete(); chk_gap = 1'b1; gap_armed = 1'b0;
    present();
    drain("t2", 300);
    chk_gap = 1'b0;
    for (int i = 0; i < 10; i++) exp_ord[i] = (i == 4 || i == 9) ? 8'h6E : 8'hC7;
    check("t2_nframes", 64'(order.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < order.size()) check($sformatf("t2_order%0d", i), 64'(order[i]), 64'(exp_ord[i]));
    end
    sec_pulse();
    check("t2_ctl_fps", 64'(ctl_fps), 64'd8);
    check("t2_gen_fps", 64'(gen_fps), 64'd2);

    // Runaway gen frame: watchdog abort.
    s_len[0] = 0; s_nfrm[0] = 1; n_gnt[0] = 0; abort_seen = 0; abort_cyc = -1;
    present();
    k = 0; saw = 1'b0;
    while (k < 60) begin
      step();
      k++;
      if (gen_gnt) saw = 1'b1;
      else if (saw) break;
    end
    check("t3_gnt_dropped", 64'(k < 60), 64'd1);
    s_nfrm[0] = 0; s_idx[0] = 0; s_frm[0]++;
    present();
    repeat (6) step();
    check("t3_words_fwd", 64'(n_gnt[0]), 64'(MAXW - 1));
    check("t3_abort_seen", 64'(abort_seen), 64'd1);
    check("t3_abort_slot", 64'(abort_cyc - last_data_cyc), 64'd1);
    check("t3_abort_count", 64'(abort_count), 64'd1);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    sec_pulse();
    check("t3_gen_fps", 64'(gen_fps), 64'd0);

    // tx_enable falls mid-frame: frame completes, no further gen grant, ctl still served.
    s_len[0] = 6; s_nfrm[0] = 2; n_gnt[0] = 0; n_gnt[1] = 0;
    present();
    k = 0;
    while (!(gen_gnt && s_idx[0] == 2) && k < 20) begin step(); k++; end
    tx_enable = 1'b0;
    while (s_nfrm[0] != 1 && k < 40) begin step(); k++; end
    s_len[1] = 4; s_nfrm[1] = 1;
    present();
    while (s_nfrm[1] != 0 && k < 80) begin step(); k++; end
    check("t4_in_budget", 64'(k < 80), 64'd1);
    repeat (10) step();
    check("t4_gen_words", 64'(n_gnt[0]), 64'd6);
    check("t4_ctl_words", 64'(n_gnt[1]), 64'd4);
    check("t4_gen_left", 64'(s_nfrm[0]), 64'd1);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);
    s_nfrm[0] = 0; s_idx[0] = 0; tx_enable = 1'b1;
    present();
    step();

    // Per-second stats with eof coinciding with sec_oneshot.
    sec_pulse();
    s_len[0] = 3; s_nfrm[0] = 4; base = s_frm[0];
    present();
    k = 0;
    while (!(gen_gnt && gen_eof && s_frm[0] == base + 3) && k < 60) begin step(); k++; end
    check("t5_found_eof", 64'(k < 60), 64'd1);
    sec_pulse();
    check("t5_gen_fps_3", 64'(gen_fps), 64'd3);
    drain("t5", 40);
    sec_pulse();
    check("t5_gen_fps_1", 64'(gen_fps), 64'd1);

    // Reset during word 5 of a ctl frame, with a gen frame already counted.
    s_len[0] = 3; s_nfrm[0] = 1;
    present();
    drain("t6_gen", 40);
    s_len[1] = 8; s_nfrm[1] = 1;
    present();
    k = 0;
    while (!(ctl_gnt && s_idx[1] == 4) && k < 30) begin step(); k++; end
    check("t6_found_word5", 64'(k < 30), 64'd1);
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    s_nfrm[1] = 0; s_idx[1] = 0; s_frm[1]++;
    present();
    check("t6_ctl_gnt", 64'(ctl_gnt), 64'd0);
    check("t6_gen_gnt", 64'(gen_gnt), 64'd0);
    check("t6_txd", xgmii_txd, IDLE_W);
    check("t6_txc", 64'(xgmii_txc), 64'hFF);
    check("t6_aborts", 64'(abort_count), 64'd0);
    check("t6_gen_fps", 64'(gen_fps), 64'd0);
    check("t6_ctl_fps", 64'(ctl_fps), 64'd0);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    step();
    s_len[1] = 3; s_nfrm[1] = 1; n_gnt[1] = 0;
    present();
    step();
    check("t6_fresh_gnt", 64'(ctl_gnt), 64'd1);
    drain("t6_ctl", 40);
    check("t6_fresh_words", 64'(n_gnt[1]), 64'd3);
    sec_pulse();
    check("t6_post_gen_fps", 64'(gen_fps), 64'd0);
    check("t6_post_ctl_fps", 64'(ctl_fps), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
